// File: rtl/controle_paridade_pkg.sv
// Shared definitions for the parity-checked serial receiver.
// Holds the FSM state encoding, the frame constants and the default width
// of the parity-error counter.
package controle_paridade_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        DADOS    = 2'd1,
        PARIDADE = 2'd2,
        ENTREGA  = 2'd3
    } estado_t;

    localparam int unsigned N_DADOS             = 5;
    localparam logic        START_BIT           = 1'b0;
    localparam int unsigned LARGURA_CONT_PADRAO = 8;

endpackage

// File: rtl/bitparidade.sv
// Even-parity checker for a 5-bit word plus its parity bit.
// Ports:
//   B1..B5      : data bits
//   bitparidade : received parity bit
//   saida       : 1 when bitparidade equals B1^B2^B3^B4^B5
module bitparidade (
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic B4,
    input  logic B5,
    input  logic bitparidade,
    output logic saida
);

    assign saida = ~(B1 ^ B2 ^ B3 ^ B4 ^ B5 ^ bitparidade);

endmodule

// File: rtl/controle_paridade.sv
// Serial receiver for frames of: start bit 0, B1..B5, even parity bit.
// The received word is presented with a valid/ready handshake and frames
// whose parity bit mismatches are counted (saturating counter).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   serial_in             : serial line bit
//   serial_valido         : serial_in valid this cycle
//   serial_pronto         : block accepts a serial bit this cycle
//   dado                  : received word, dado[0]=B1 .. dado[4]=B5
//   dado_valido           : dado and erro_paridade valid
//   dado_pronto           : consumer accepts dado
//   erro_paridade         : received parity bit mismatched
//   limpar                : synchronous clear of cont_erros (wins over increment)
//   cont_erros            : number of frames delivered with a parity error
module controle_paridade
    import controle_paridade_pkg::*;
#(
    parameter int unsigned LARGURA_CONT = LARGURA_CONT_PADRAO
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    serial_in,
    input  logic                    serial_valido,
    output logic                    serial_pronto,
    output logic [N_DADOS-1:0]      dado,
    output logic                    dado_valido,
    input  logic                    dado_pronto,
    output logic                    erro_paridade,
    input  logic                    limpar,
    output logic [LARGURA_CONT-1:0] cont_erros
);

    localparam logic [2:0] IDX_ULTIMO = 3'(N_DADOS - 1);

    estado_t                 estado_q;
    logic [2:0]              idx_q;
    logic [N_DADOS-1:0]      dado_q;
    logic                    valido_q;
    logic                    erro_q;
    logic [LARGURA_CONT-1:0] cont_q;
    logic [LARGURA_CONT-1:0] cont_d;

    logic batida;
    logic saida_chk;
    logic incrementa;

    assign serial_pronto = (estado_q != ENTREGA);
    assign batida        = serial_valido & serial_pronto;

    // The checker sees the stored word and the live serial bit, so its
    // result is only meaningful on the parity beat.
    bitparidade u_chk (
        .B1          (dado_q[0]),
        .B2          (dado_q[1]),
        .B3          (dado_q[2]),
        .B4          (dado_q[3]),
        .B5          (dado_q[4]),
        .bitparidade (serial_in),
        .saida       (saida_chk)
    );

    assign incrementa = batida && (estado_q == PARIDADE) && !saida_chk;

    always_comb begin
        cont_d = cont_q;
        if (limpar) begin
            cont_d = '0;
        end else if (incrementa && (cont_q != '1)) begin
            cont_d = cont_q + LARGURA_CONT'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            idx_q    <= '0;
            dado_q   <= '0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
            cont_q   <= '0;
        end else begin
            cont_q <= cont_d;
            case (estado_q)
                OCIOSO: begin
                    // Idle-line ones are simply dropped.
                    if (batida && (serial_in == START_BIT)) begin
                        estado_q <= DADOS;
                        idx_q    <= '0;
                    end
                end
                DADOS: begin
                    if (batida) begin
                        dado_q[idx_q] <= serial_in;
                        idx_q         <= idx_q + 3'd1;
                        if (idx_q == IDX_ULTIMO) begin
                            estado_q <= PARIDADE;
                        end
                    end
                end
                PARIDADE: begin
                    if (batida) begin
                        erro_q   <= ~saida_chk;
                        valido_q <= 1'b1;
                        estado_q <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    if (dado_pronto) begin
                        valido_q <= 1'b0;
                        estado_q <= OCIOSO;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign dado          = dado_q;
    assign dado_valido   = valido_q;
    assign erro_paridade = erro_q;
    assign cont_erros    = cont_q;

endmodule

// File: tb/tb_controle_paridade.sv
// Self-checking bench for controle_paridade: a frame-level model predicts
// the handshake, word, parity flag and counters for a default-width
// instance and a 2-bit-counter instance driven by the same stimulus.
module tb_controle_paridade;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic       serial_valido;
    logic       dado_pronto;
    logic       limpar;

    logic       pronto8, valido8, erro8;
    logic [4:0] dado8;
    logic [7:0] cont8;
    logic       pronto2, valido2, erro2;
    logic [4:0] dado2;
    logic [1:0] cont2;

    int checks = 0;
    int erros  = 0;
    bit ativo  = 1'b0;

    always #5 clk = ~clk;

    controle_paridade dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .serial_in     (serial_in),
        .serial_valido (serial_valido),
        .serial_pronto (pronto8),
        .dado          (dado8),
        .dado_valido   (valido8),
        .dado_pronto   (dado_pronto),
        .erro_paridade (erro8),
        .limpar        (limpar),
        .cont_erros    (cont8)
    );

    controle_paridade #(.LARGURA_CONT(2)) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .serial_in     (serial_in),
        .serial_valido (serial_valido),
        .serial_pronto (pronto2),
        .dado          (dado2),
        .dado_valido   (valido2),
        .dado_pronto   (dado_pronto),
        .erro_paridade (erro2),
        .limpar        (limpar),
        .cont_erros    (cont2)
    );

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            erros++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int unsigned n_bits  = 0;      // 0: waiting for start, 1..5: next data bit, 6: parity
    bit [4:0]    m_buf   = '0;
    bit [4:0]    m_dado  = '0;
    bit          m_valid = 1'b0;
    bit          m_err   = 1'b0;
    int unsigned m_cont8 = 0;
    int unsigned m_cont2 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_bits  = 0;
            m_buf   = '0;
            m_dado  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_cont8 = 0;
            m_cont2 = 0;
        end else begin
            bit inc;
            inc = 1'b0;
            if (m_valid) begin
                if (dado_pronto) m_valid = 1'b0;
            end else if (serial_valido) begin
                if (n_bits == 0) begin
                    if (serial_in == 1'b0) n_bits = 1;
                end else if (n_bits <= 5) begin
                    m_buf[n_bits-1] = serial_in;
                    n_bits++;
                end else begin
                    m_dado  = m_buf;
                    m_err   = (($countones(m_buf) % 2) != int'(serial_in));
                    m_valid = 1'b1;
                    n_bits  = 0;
                    inc     = m_err;
                end
            end
            if (limpar) begin
                m_cont8 = 0;
                m_cont2 = 0;
            end else if (inc) begin
                if (m_cont8 < 255) m_cont8++;
                if (m_cont2 < 3)   m_cont2++;
            end
        end
    end

    always @(negedge clk) begin
        if (ativo) begin
            chk("valido8", valido8, m_valid);
            chk("valido2", valido2, m_valid);
            chk("pronto8", pronto8, !m_valid);
            chk("pronto2", pronto2, !m_valid);
            chk("cont8", cont8, m_cont8);
            chk("cont2", cont2, m_cont2);
            if (m_valid) begin
                chk("dado8", dado8, m_dado);
                chk("dado2", dado2, m_dado);
                chk("erro8", erro8, m_err);
                chk("erro2", erro2, m_err);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic bit_(input logic b);
        serial_valido = 1'b1;
        serial_in     = b;
        @(posedge clk); #1;
        serial_valido = 1'b0;
        serial_in     = 1'b0;
    endtask

    task automatic quadro(input logic [4:0] d, input logic p, input int unsigned gap, input logic clr);
        bit_(1'b0);
        for (int unsigned i = 0; i < 5; i++) begin
            if (i == 3) begin
                for (int unsigned g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
            end
            bit_(d[i]);
        end
        limpar = clr;
        bit_(p);
        limpar = 1'b0;
    endtask

    task automatic aceita();
        dado_pronto = 1'b1;
        @(posedge clk); #1;
        dado_pronto = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        serial_in     = 1'b0;
        serial_valido = 1'b0;
        dado_pronto   = 1'b0;
        limpar        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dado", dado8, 5'b00000);
        chk("rst_valido", valido8, 1'b0);
        chk("rst_erro", erro8, 1'b0);
        chk("rst_cont", cont8, 8'd0);
        chk("rst_pronto", pronto8, 1'b1);
        rst_n = 1'b1;
        ativo = 1'b1;
        @(posedge clk); #1;

        // good frame, one-cycle latency
        quadro(5'b01101, 1'b1, 0, 1'b0);
        chk("ok_valido", valido8, 1'b1);
        chk("ok_dado", dado8, 5'b01101);
        chk("ok_erro", erro8, 1'b0);
        chk("ok_cont", cont8, 8'd0);
        aceita();

        // parity error, consumer stalls while beats keep arriving
        quadro(5'b01101, 1'b0, 0, 1'b0);
        chk("err_erro", erro8, 1'b1);
        chk("err_cont8", cont8, 8'd1);
        chk("err_cont2", cont2, 2'd1);
        for (int k = 0; k < 5; k++) begin
            serial_valido = 1'b1;
            serial_in     = k[0];
            @(posedge clk); #1;
            chk("hold_dado", dado8, 5'b01101);
            chk("hold_erro", erro8, 1'b1);
            chk("hold_pronto", pronto8, 1'b0);
        end
        serial_valido = 1'b0;
        aceita();
        chk("back_idle", pronto8, 1'b1);

        // idle ones before an all-zero frame
        bit_(1'b1); bit_(1'b1); bit_(1'b1);
        quadro(5'b00000, 1'b0, 0, 1'b0);
        chk("zero_dado", dado8, 5'b00000);
        chk("zero_erro", erro8, 1'b0);
        aceita();

        // 4-cycle stall between B3 and B4
        quadro(5'b10110, 1'b1, 4, 1'b0);
        chk("gap_dado", dado8, 5'b10110);
        chk("gap_erro", erro8, 1'b0);
        aceita();

        // saturation of the 2-bit counter
        for (int f = 0; f < 5; f++) begin
            quadro(5'b00001, 1'b0, 0, 1'b0);
            aceita();
        end
        chk("sat_cont2", cont2, 2'd3);
        chk("sat_cont8", cont8, 8'd6);

        // clear coinciding with an error delivery
        quadro(5'b00001, 1'b0, 0, 1'b1);
        chk("clr_erro", erro8, 1'b1);
        chk("clr_cont8", cont8, 8'd0);
        chk("clr_cont2", cont2, 2'd0);
        aceita();

        // reset while a frame is pending delivery
        quadro(5'b00001, 1'b0, 0, 1'b0);
        chk("pend_cont8", cont8, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("rstE_valido", valido8, 1'b0);
        chk("rstE_cont", cont8, 8'd0);
        chk("rstE_pronto", pronto8, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // reset after B2 of a frame, then a clean frame
        bit_(1'b0); bit_(1'b1); bit_(1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstD_dado", dado8, 5'b00000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        quadro(5'b00011, 1'b0, 0, 1'b0);
        chk("abort_valido", valido8, 1'b1);
        chk("abort_dado", dado8, 5'b00011);
        chk("abort_erro", erro8, 1'b0);
        aceita();

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

endmodule

// File: doc/controle_paridade.md
CONTROLE_PARIDADE -- requirements
Module: controle_paridade

Interface
REQ-001 SHALL have parameter LARGURA_CONT, default 8, giving the width of the parity-error counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port serial_in, input, 1, the serial line bit.
REQ-005 SHALL have port serial_valido, input, 1; serial_in is valid this cycle.
REQ-006 SHALL have port serial_pronto, output, 1; the block accepts a serial bit this cycle.
REQ-007 SHALL have port dado, output, 5, the received word; dado[0]=B1 … dado[4]=B5.
REQ-008 SHALL have port dado_valido, output, 1; dado and erro_paridade are valid.
REQ-009 SHALL have port dado_pronto, input, 1; the consumer accepts dado.
REQ-010 SHALL have port erro_paridade, output, 1; the received parity bit mismatched.
REQ-011 SHALL have port limpar, input, 1, a synchronous clear of cont_erros.
REQ-012 SHALL have port cont_erros, output, LARGURA_CONT, the count of frames with a parity error.

Function
REQ-013 SHALL accept a serial bit only on a cycle with serial_valido=1 and serial_pronto=1 (a "beat").
REQ-014 SHALL frame data as: start bit 0, then B1..B5 in order, then one parity bit (7 beats).
REQ-015 SHALL use even parity: the frame is correct when parity bit = B1^B2^B3^B4^B5.
REQ-016 SHALL run an FSM with states OCIOSO, DADOS, PARIDADE, ENTREGA.
REQ-017 In OCIOSO: a beat with serial_in=0 moves to DADOS with bit index 0; a beat with serial_in=1 is discarded (idle line).
REQ-018 In DADOS: each beat stores serial_in at dado[index] and increments the 3-bit index; the beat with index=4 moves to PARIDADE.
REQ-019 In PARIDADE: the beat stores the parity bit, evaluates the checker and moves to ENTREGA.
REQ-020 In ENTREGA: dado_valido=1, and dado and erro_paridade are held stable until a cycle with dado_pronto=1, after which the FSM is in OCIOSO on the next cycle.
REQ-021 Latency SHALL be 1 cycle: dado_valido rises on the cycle after the parity beat.
REQ-022 serial_pronto SHALL be 1 in OCIOSO, DADOS and PARIDADE, and 0 in ENTREGA; serial_in is ignored while serial_pronto=0.
REQ-023 Cycles with serial_valido=0 in the middle of a frame SHALL stall the FSM without losing state.
REQ-024 A frame with a parity error SHALL still be delivered with erro_paridade=1.
REQ-025 cont_erros SHALL increment on the cycle of the transition to ENTREGA with an error, and saturate at 2^LARGURA_CONT-1.
REQ-026 limpar=1 SHALL zero cont_erros on the next edge; if it coincides with an increment, limpar wins (result 0).
REQ-027 dado_valido, erro_paridade and cont_erros SHALL be registered outputs; serial_pronto is decoded from the state.

Reset
REQ-028 rst_n=0 SHALL immediately force: state OCIOSO, index 0, dado=0, dado_valido=0, erro_paridade=0, cont_erros=0, serial_pronto=1 (after release).
REQ-029 Reset mid-frame or in ENTREGA SHALL discard the partial or pending frame; the first beat after release is treated as in OCIOSO.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding (2 bits), frame constants (N_DADOS=5, START_BIT=0) and the default LARGURA_CONT.
REQ-031 Parity comparison SHALL be done by one instance of the team's existing checker bitparidade (inputs B1..B5 and bitparidade, output saida=1 when parity is correct); erro_paridade = ~saida, registered.
REQ-032 No other sub-modules are permitted; FSM, index and counter belong in controle_paridade.

Verification
REQ-033 Beats 0,1,0,1,1,0,1 (B1..B5=1,0,1,1,0; parity 1) -> 1 cycle later dado=5'b01101, dado_valido=1, erro_paridade=0, cont_erros=0.
REQ-034 Same data with parity 0 -> dado=5'b01101, erro_paridade=1, cont_erros=1; dado_pronto held at 0 for 5 cycles -> outputs stable, serial_pronto=0, beats ignored.
REQ-035 Frame 0,0,0,0,0,0,0 preceded by three idle beats of 1 -> dado=0, erro_paridade=0 (idle bits discarded).
REQ-036 serial_valido=0 for 4 cycles between B3 and B4 -> correct word and parity as if contiguous.
REQ-037 With LARGURA_CONT=2, 5 error frames -> cont_erros=3 (saturated); limpar=1 coinciding with an error-frame delivery -> cont_erros=0.
REQ-038 rst_n=0 after B2 of a frame, then a full valid frame 0,1,1,0,0,0,0 -> dado=5'b00011, erro_paridade=0, no residue from the aborted frame.
